// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fetch_pkg
// Description : Shared types and defaults for the instruction-fetch block.
// Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int unsigned c_DEFAULT_RESET_PC = 0;
  localparam int unsigned c_DEFAULT_DEPTH    = 12;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word-index PC is fetchable only inside the instruction memory.
  function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned depth);
    return pc < depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Two-entry shift queue of fetched words; head always in slot 0.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  fetch_entry_t r_entry0;
  fetch_entry_t r_entry1;
  logic [1:0]   r_count;
  logic         w_do_pop;
  logic         w_do_push;

  assign w_do_pop  = pop & (r_count != 2'd0);
  assign w_do_push = push & ((r_count != 2'd2) | w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count  <= 2'd0;
      r_entry0 <= '0;
      r_entry1 <= '0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10: begin
          if (r_count == 2'd0) r_entry0 <= push_data;
          else                 r_entry1 <= push_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_entry0 <= r_entry1;
          r_count  <= r_count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (r_count == 2'd1) begin
            r_entry0 <= push_data;
          end else begin
            r_entry0 <= r_entry1;
            r_entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count      = r_count;
  assign head_valid = (r_count != 2'd0);
  assign head       = r_entry0;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch controller: owns the PC, issues one memory
//               read per cycle, buffers words for decode, handles redirects.
//               Optional event counters enabled by defining FETCH_PERF_EN.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned RESET_PC = c_DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = c_DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        fault,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
);

  localparam logic [31:0] c_RESET_PC = 32'(RESET_PC);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_inflight_pc;
  logic         r_inflight;
  logic         r_fault;
  logic [1:0]   w_count;
  logic [2:0]   w_slots_used;
  logic         w_head_valid;
  logic         w_in_range;
  logic         w_pop;
  logic         w_push;
  logic         w_issue;
  fetch_entry_t w_head;
  fetch_entry_t w_push_data;

  assign w_in_range   = pc_in_range(r_pc, DEPTH);
  assign w_pop        = w_head_valid & if_ready;
  assign w_slots_used = {1'b0, w_count} + {2'b00, r_inflight};
  // A redirect kills the response arriving this cycle.
  assign w_push       = r_inflight & ~redirect_valid;
  assign w_push_data  = '{pc: r_inflight_pc, instr: imem_rdata};

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid)                     w_state_next = RUN;
    else if (r_state == RUN && !w_in_range) w_state_next = HALT;
  end

  // Output logic: issue only if the response has a guaranteed slot next cycle.
  always_comb begin
    w_issue = 1'b0;
    if (rst && !redirect_valid && r_state == RUN && w_in_range)
      w_issue = (w_slots_used < 3'd2) || w_pop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc          <= c_RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'd0;
      r_fault       <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
      if (redirect_valid) begin
        r_pc    <= redirect_pc;
        r_fault <= 1'b0;
      end else begin
        if (w_issue)                      r_pc    <= r_pc + 32'd1;
        if (r_state == RUN && !w_in_range) r_fault <= 1'b1;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_data  (w_push_data),
    .pop        (w_pop),
    .flush      (redirect_valid),
    .count      (w_count),
    .head_valid (w_head_valid),
    .head       (w_head)
  );

  assign imem_en   = w_issue;
  assign imem_addr = r_pc;
  assign if_valid  = w_head_valid;
  assign if_instr  = w_head.instr;
  assign if_pc     = w_head.pc;
  assign fault     = r_fault;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_issued <= 32'd0;
      r_perf_stall  <= 32'd0;
    end else begin
      if (w_issue)                         r_perf_issued <= r_perf_issued + 32'd1;
      if (r_state == RUN && !w_head_valid) r_perf_stall  <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`else
  assign perf_issued = 32'd0;
  assign perf_stall  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed and randomized checks of fetch_ctrl against a
//               stream-level model (sequential PCs from each restart point).
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam int unsigned DEPTH    = 12;
  localparam int unsigned RESET_PC = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
  logic        fault;
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;

  int          errors = 0;
  int          checks = 0;
  int unsigned exp_next;
  int unsigned accepted;
  int unsigned got;
  logic        do_rst;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .fault          (fault),
    .perf_issued    (perf_issued),
    .perf_stall     (perf_stall)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'(DEPTH)) ? (a + 32'd100) : (32'hDEAD0000 | a);
  endfunction

  // Synchronous memory: data valid the cycle after a read, held otherwise.
  always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", 32'(imem_en), 32'd0);
    check("rst_addr", imem_addr, 32'(RESET_PC));
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_perf_issued", perf_issued, 32'd0);
    check("rst_perf_stall", perf_stall, 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Free-running fetch after reset release.
    apply_reset();
    if_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      check("run_en", 32'(imem_en), 32'd1);
      check("run_addr", imem_addr, 32'(k));
      if (k < 2) begin
        check("run_valid_lo", 32'(if_valid), 32'd0);
      end else begin
        check("run_valid", 32'(if_valid), 32'd1);
        check("run_pc", if_pc, 32'(k - 2));
        check("run_instr", if_instr, 32'(k - 2 + 100));
      end
      cyc();
    end
`ifndef FETCH_PERF_EN
    check("perf_issued_tied", perf_issued, 32'd0);
    check("perf_stall_tied", perf_stall, 32'd0);
`endif

    // Backpressure: decode stalls, queue fills with PC 0 and 1.
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      settle();
      check("bp_en", 32'(imem_en), (k < 2) ? 32'd1 : 32'd0);
      if (k < 2) check("bp_addr", imem_addr, 32'(k));
      if (k >= 2) begin
        check("bp_valid", 32'(if_valid), 32'd1);
        check("bp_head_pc", if_pc, 32'd0);
      end
      cyc();
    end
    if_ready = 1'b1;
    settle();
    check("bp_pop_en", 32'(imem_en), 32'd1);
    check("bp_pop_addr", imem_addr, 32'd2);
    check("bp_pop_pc0", if_pc, 32'd0);
    check("bp_pop_instr0", if_instr, 32'd100);
    cyc();
    settle();
    check("bp_pc1", if_pc, 32'd1);
    check("bp_instr1", if_instr, 32'd101);
    check("bp_addr3", imem_addr, 32'd3);
    cyc();
    settle();
    check("bp_pc2", if_pc, 32'd2);
    check("bp_instr2", if_instr, 32'd102);
    check("bp_addr4", imem_addr, 32'd4);
    cyc();

    // Redirect with a held entry and a response in flight.
    if_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'd7;
    settle();
    check("rd_en_lo", 32'(imem_en), 32'd0);
    check("rd_head_pc3", if_pc, 32'd3);
    cyc();
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    settle();
    check("rd_flushed", 32'(if_valid), 32'd0);
    check("rd_issue_en", 32'(imem_en), 32'd1);
    check("rd_issue_addr", imem_addr, 32'd7);
    cyc();
    settle();
    check("rd_still_empty", 32'(if_valid), 32'd0);
    check("rd_addr8", imem_addr, 32'd8);
    cyc();

    // Run off the end of memory: PC 11 delivered, no read at 12, fault, halt.
    for (int k = 13; k < 18; k++) begin
      settle();
      check("end_valid", 32'(if_valid), 32'd1);
      check("end_pc", if_pc, 32'(k - 6));
      check("end_instr", if_instr, 32'(k - 6 + 100));
      check("end_en", 32'(imem_en), (k < 16) ? 32'd1 : 32'd0);
      if (k < 16) check("end_addr", imem_addr, 32'(k - 4));
      check("end_fault", 32'(fault), (k == 17) ? 32'd1 : 32'd0);
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      settle();
      check("halt_valid", 32'(if_valid), 32'd0);
      check("halt_en", 32'(imem_en), 32'd0);
      check("halt_fault", 32'(fault), 32'd1);
      cyc();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'd3;
    settle();
    check("halt_rd_fault", 32'(fault), 32'd1);
    check("halt_rd_en", 32'(imem_en), 32'd0);
    cyc();
    redirect_valid = 1'b0;
    settle();
    check("resume_fault", 32'(fault), 32'd0);
    check("resume_en", 32'(imem_en), 32'd1);
    check("resume_addr", imem_addr, 32'd3);
    cyc();
    settle();
    check("resume_valid_lo", 32'(if_valid), 32'd0);
    cyc();
    settle();
    check("resume_pc3", if_pc, 32'd3);
    check("resume_instr3", if_instr, 32'd103);
    cyc();
    settle();
    check("resume_pc4", if_pc, 32'd4);
    cyc();

    // One-cycle reset pulse mid-stream.
    rst = 1'b0;
    settle();
    check("mid_rst_en", 32'(imem_en), 32'd0);
    cyc();
    rst = 1'b1;
    settle();
    check("mid_rst_valid", 32'(if_valid), 32'd0);
    check("mid_rst_pc", if_pc, 32'd0);
    check("mid_rst_instr", if_instr, 32'd0);
    check("mid_rst_fault", 32'(fault), 32'd0);
    check("mid_rst_addr", imem_addr, 32'(RESET_PC));
    check("mid_rst_en_hi", 32'(imem_en), 32'd1);
    cyc();
    settle();
    check("mid_rst_no_leftover", 32'(if_valid), 32'd0);
    cyc();
    settle();
    check("mid_rst_first_pc", if_pc, 32'(RESET_PC));
    check("mid_rst_first_instr", if_instr, 32'(RESET_PC + 100));
    cyc();

`ifdef FETCH_PERF_EN
    // Ten free-running cycles, then redirect bubbles.
    apply_reset();
    if_ready = 1'b1;
    repeat (10) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'd0;
    repeat (3) cyc();
    redirect_valid = 1'b0;
    repeat (2) cyc();
    settle();
    check("perf_issued", perf_issued, 32'd12);
    check("perf_stall", perf_stall, 32'd6);
`endif

    // Randomized traffic against the stream model.
    apply_reset();
    exp_next = RESET_PC;
    accepted = 0;
    for (int k = 0; k < 600; k++) begin
      do_rst = ($urandom_range(0, 99) == 0);
      if_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 6);
      redirect_pc = 32'($urandom_range(0, DEPTH + 2));
      if (do_rst) begin
        rst = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
      end else begin
        rst = 1'b1;
      end
      settle();
      if (do_rst) begin
        exp_next = RESET_PC;
      end else begin
        if (exp_next + 2 < DEPTH) check("rnd_fault_early", 32'(fault), 32'd0);
        if (if_valid && if_ready) begin
          check("rnd_pc", if_pc, exp_next);
          check("rnd_instr", if_instr, exp_next + 100);
          check("rnd_in_range", 32'(exp_next < DEPTH), 32'd1);
          exp_next++;
          accepted++;
        end
        if (redirect_valid) exp_next = redirect_pc;
      end
      cyc();
    end
    check("rnd_progress", 32'(accepted > 0), 32'd1);

    // Drain the whole memory from PC 0 within a bounded window.
    rst = 1'b1;
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd0;
    cyc();
    redirect_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      settle();
      if (if_valid) begin
        check("drain_pc", if_pc, got);
        check("drain_instr", if_instr, got + 100);
        got++;
      end
      cyc();
    end
    check("drain_count", got, 32'(DEPTH));
    check("drain_fault", 32'(fault), 32'd1);
    check("drain_en", 32'(imem_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the pipelined core. It sequences the synchronous instruction memory by owning the PC, issuing one read per cycle, and capturing each returned word. Fetched words are buffered in a 2-entry queue and presented to decode with a valid/ready handshake. Branch/jump redirects from execute flush the queue and restart fetch at the new PC.

## Interface
- RESET_PC, 0: PC loaded at reset (word index).
- DEPTH, 12: instruction memory words; valid PCs are 0..DEPTH-1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- redirect_valid  in  1  execute requests PC change.
- redirect_pc  in  32  new PC (word index).
- imem_en  out  1  memory read enable.
- imem_addr  out  32  memory read address (= current PC).
- imem_rdata  in  32  memory data; valid the cycle after imem_en=1, held otherwise.
- if_valid  out  1  queue head valid.
- if_instr  out  32  queue head instruction.
- if_pc  out  32  queue head PC.
- if_ready  in  1  decode accepts the head this cycle.
- fault  out  1  sticky: fetch attempted at PC >= DEPTH.
- perf_issued  out  32  reads issued (FETCH_PERF_EN only).
- perf_stall  out  32  cycles with if_valid=0 while in RUN (FETCH_PERF_EN only).

## Operation
- FSM states RUN and HALT. Reset enters RUN with pc=RESET_PC, queue empty, inflight=0, fault=0.
- Issue condition in RUN: pc < DEPTH, no redirect this cycle, and (count + inflight < 2 or pop). Pop = if_valid & if_ready.
- On issue: imem_en=1, imem_addr=pc, inflight set, pc increments by 1 (32-bit wrap).
- The cycle after an issue: imem_rdata and the issued PC are pushed into the queue unless killed. Push and pop in the same cycle leave count unchanged. Count never exceeds 2.
- pc >= DEPTH in RUN: no issue; next state HALT; fault set. In-flight data and queue contents still drain to decode.
- HALT: no issue. Exits only on redirect.
- Redirect (any state, priority over all else): queue flushed, in-flight response killed (not pushed), pc=redirect_pc, fault cleared, state=RUN, imem_en=0 that cycle. A pop in the same cycle is still a valid acceptance.
- imem_en is never asserted when the response slot cannot be absorbed.

## Timing
- Reset values: imem_en=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fault=0, perf counters=0.
- First imem_en is in the first cycle after rst goes high. Data arrives in cycle +1; if_valid is in cycle +2.
- Steady state with if_ready held 1: one instruction per cycle.
- Redirect in cycle N: the redirect_pc read is issued in N+1, and if_valid for it is in N+3.
- Outputs if_* come from registers; imem_en depends combinationally on if_ready and redirect_valid.
- rst low mid-operation: all state returns to reset values at the next edge, and the in-flight response is discarded.

## Configuration
- FETCH_PERF_EN defined: perf_issued counts issue cycles, perf_stall counts RUN cycles with if_valid=0. Both are 32-bit, wrap, and reset to 0.
- Not defined: the counter logic is removed and perf_issued and perf_stall are tied to 0.

## Structure
- fetch_pkg: state enum (RUN, HALT), fetch entry struct {pc[31:0], instr[31:0]}, default RESET_PC and DEPTH constants.
- Sub-module fetch_fifo: a 2-entry queue with push/pop/flush, count, and head outputs. fetch_ctrl holds the FSM, PC, inflight/kill logic, and counters.

## Test plan
- Reset release, if_ready=1, memory[i]=i+100 → imem_addr 0,1,2… on consecutive cycles; if_valid from cycle 2; if_instr 100,101,102 with matching if_pc.
- if_ready=0 for 5 cycles after the first fetch → exactly 2 entries held (PC 0,1); imem_en low; PC 2 is issued only on the cycle pop occurs.
- Redirect to PC 7 while the queue is full and a read is in flight → queue empty the next cycle; no stale word reaches decode; the next if_pc is 7 with if_instr=107.
- Sequential fetch past PC 11 with DEPTH=12 → PC 11 is delivered, no read at 12, fault=1, HALT; redirect to 3 clears fault and resumes at PC 3.
- rst driven low for one cycle mid-stream → all outputs return to reset values; fetch restarts at RESET_PC with no leftover entries.
- With FETCH_PERF_EN defined: 10 cycles free-running then 4 cycles stalled by redirect bubbles → perf_issued and perf_stall match the scoreboard counts.
